clip_effect_tx: RTL
===================

Name: clip_effect_tx

Overview:
Producer side of the effect-to-mixer sample handshake. Accepts raw audio samples from the sample source and buffers them in a 2-entry queue. Each sample is then presented as a dry copy (o_data_sw0) and a clipped, gain-restored copy (o_data_sw1), held with o_dv until the mixer acknowledges with a read-done pulse. Sits between the ADC/sample front end and the effect mixer.

Parameters:
DATA_WIDTH, 16, sample width, signed two's complement.
CLIP_LEVEL, 8192, positive clip threshold; the clip range is [-CLIP_LEVEL, +CLIP_LEVEL].
GAIN_SHIFT, 1, left shift applied after clipping (makeup gain), 0..3.
TIMEOUT, 1024, maximum PRESENT cycles waiting for i_read_done before the sample is abandoned.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_sample  in  DATA_WIDTH  signed input sample
i_sample_valid  in  1  one-cycle strobe; i_sample valid this cycle
i_read_ready  in  1  mixer idle/ready indication (status only, not gating)
i_read_done  in  1  mixer capture acknowledge (one-cycle pulse)
o_dv  out  1  o_data_sw0/o_data_sw1 valid and stable
o_data_sw0  out  DATA_WIDTH  dry sample
o_data_sw1  out  DATA_WIDTH  clipped, gained sample
o_overrun  out  1  one-cycle pulse: input sample dropped, queue full
o_timeout  out  1  one-cycle pulse: presented sample abandoned
o_overrun_cnt  out  8  saturating count of dropped samples
o_busy  out  1  high when state is not IDLE or queue is non-empty

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE, queue emptied. All outputs 0, including both data outputs and o_overrun_cnt. Timeout counter 0. Reset mid-PRESENT drops o_dv on the next edge, and the held sample is lost.
- Input queue: 2-entry FIFO.
  - Push on i_sample_valid.
  - If the queue is full and there is no pop this cycle: sample dropped, o_overrun=1 for one cycle, o_overrun_cnt increments and saturates at 255.
  - Simultaneous push and pop while full: push accepted, no overrun.
- States: IDLE, CLIP, GAIN, PRESENT.
  - IDLE: if queue non-empty, pop head into work register, go to CLIP; else stay.
  - CLIP: c = min(max(x, -CLIP_LEVEL), CLIP_LEVEL), registered. Go to GAIN.
  - GAIN: y = c << GAIN_SHIFT, computed in DATA_WIDTH+GAIN_SHIFT bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register o_data_sw0 = x and o_data_sw1 = y, set o_dv=1, go to PRESENT.
  - PRESENT: o_dv=1, data held constant, timeout counter increments each cycle.
    - i_read_done=1: o_dv=0 on that edge, counter cleared, go to IDLE.
    - Counter reaches TIMEOUT-1 without i_read_done: o_dv=0, o_timeout pulse, go to IDLE.
    - i_read_done and timeout in the same cycle: treated as read done, no o_timeout.
  - i_read_done outside PRESENT is ignored.
- Latency: for a sample strobed in cycle t with an empty queue and state IDLE, o_dv is first high in cycle t+4.
  - After o_dv drops, a queued sample can reassert o_dv no sooner than 4 cycles later (IDLE, CLIP, GAIN, PRESENT).
  - This leaves the mixer time to complete its add/normalise/output sequence.
- o_data_sw0/o_data_sw1 keep their last values after o_dv drops; consumers sample them only while o_dv=1.
- i_read_ready is not used to gate o_dv; o_dv may rise while the mixer is busy, and capture happens when the mixer returns to idle.

Test Plan:
1. Reset, then i_sample=20000 strobe at cycle 0 -> o_dv=1 from cycle 4 with o_data_sw0=20000, o_data_sw1=16384. Pulse i_read_done at cycle 6 -> o_dv=0 at cycle 7.
2. Samples 1000, -30000, -32768 with prompt read-done -> sw1 = 2000, -16384, -16384; sw0 echoes each input exactly.
3. GAIN_SHIFT=2, input 8192 -> sw1=32767; input -8192 -> sw1=-32768 (saturation both polarities).
4. Hold i_read_done=0, strobe 4 samples back to back -> 2 queued plus 1 in work, 4th dropped: one o_overrun pulse, o_overrun_cnt=1. Releasing read-done then delivers the 3 kept samples in order.
5. TIMEOUT=8, never acknowledge -> o_dv high exactly 8 cycles, o_timeout pulse, next queued sample presented 4 cycles later.
6. Assert reset while o_dv=1 with 2 samples queued -> o_dv=0 next cycle, o_busy=0, no further o_dv after reset releases until a new strobe.

Source files
------------

// File: rtl/clip_effect_tx.sv
// Effect-side producer: queues raw samples, presents a dry copy and a clipped,
// gain-restored copy to the mixer, and holds them until read-done or timeout.
module clip_effect_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLIP_LEVEL = 8192,
  parameter int GAIN_SHIFT = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic                         i_sample_valid,
  input  logic                         i_read_ready,
  input  logic                         i_read_done,
  output logic                         o_dv,
  output logic signed [DATA_WIDTH-1:0] o_data_sw0,
  output logic signed [DATA_WIDTH-1:0] o_data_sw1,
  output logic                         o_overrun,
  output logic                         o_timeout,
  output logic [7:0]                   o_overrun_cnt,
  output logic                         o_busy
);

  localparam int WG = DATA_WIDTH + GAIN_SHIFT;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [DATA_WIDTH-1:0] CLIP_HI = DATA_WIDTH'(CLIP_LEVEL);
  localparam logic signed [DATA_WIDTH-1:0] CLIP_LO = DATA_WIDTH'(-CLIP_LEVEL);
  localparam logic [TW-1:0]                TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CLIP, GAIN, PRESENT} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] clip_fn(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] r;
    if (x > CLIP_HI)      r = CLIP_HI;
    else if (x < CLIP_LO) r = CLIP_LO;
    else                  r = x;
    return r;
  endfunction

  // Widen, shift, then saturate if the bits above the output sign bit disagree.
  function automatic logic signed [DATA_WIDTH-1:0] gain_sat(input logic signed [DATA_WIDTH-1:0] c);
    logic signed [WG-1:0]         wide;
    logic signed [DATA_WIDTH-1:0] r;
    wide = WG'(c);
    wide = wide <<< GAIN_SHIFT;
    if (wide[WG-1:DATA_WIDTH-1] == {(GAIN_SHIFT+1){wide[WG-1]}})
      r = wide[DATA_WIDTH-1:0];
    else if (wide[WG-1])
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return r;
  endfunction

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] q_mem [2];
  logic [1:0]                   q_count;
  logic signed [DATA_WIDTH-1:0] x_p0;
  logic signed [DATA_WIDTH-1:0] c_p1;
  logic [TW-1:0]                to_cnt;
  logic                         pop, full, push, overrun, widx;
  logic                         unused_read_ready;

  // Mixer readiness is informational; presentation never waits on it.
  assign unused_read_ready = i_read_ready;

  assign pop     = (state == IDLE) && (q_count != 2'd0);
  assign full    = (q_count == 2'd2);
  assign push    = i_sample_valid && (!full || pop);
  assign overrun = i_sample_valid && full && !pop;
  // Write slot is the occupancy after any pop: count 0/1 without pop, 1/2 with pop.
  assign widx    = q_count[0] ^ pop;
  assign o_busy  = (state != IDLE) || (q_count != 2'd0);

  // Queue storage and datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (pop)  q_mem[0] <= q_mem[1];
    if (push) q_mem[widx] <= i_sample;
    // p0: work register loaded from queue head
    if (pop) x_p0 <= q_mem[0];
    // p1: clipped value
    if (state == CLIP) c_p1 <= clip_fn(x_p0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      q_count       <= 2'd0;
      to_cnt        <= '0;
      o_dv          <= 1'b0;
      o_data_sw0    <= '0;
      o_data_sw1    <= '0;
      o_overrun     <= 1'b0;
      o_timeout     <= 1'b0;
      o_overrun_cnt <= 8'd0;
    end else begin
      q_count   <= q_count + {1'b0, push} - {1'b0, pop};
      o_overrun <= overrun;
      o_timeout <= 1'b0;
      if (overrun && (o_overrun_cnt != 8'hFF))
        o_overrun_cnt <= o_overrun_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (pop) state <= CLIP;
        end
        CLIP: begin
          state <= GAIN;
        end
        // p2: presented outputs
        GAIN: begin
          o_data_sw0 <= x_p0;
          o_data_sw1 <= gain_sat(c_p1);
          o_dv       <= 1'b1;
          to_cnt     <= '0;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (i_read_done) begin
            o_dv   <= 1'b0;
            to_cnt <= '0;
            state  <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            o_dv      <= 1'b0;
            o_timeout <= 1'b1;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
